// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : time_pkg
//  Purpose  : Shared mode/field encodings, BCD limits and the two-digit BCD
//             increment used by the time/alarm setting front end.
//  Revision : 1.0 - initial release
// ============================================================================
package time_pkg;

    // Edit mode, also driven out for display blinking
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_TIME = 2'd1,
        MODE_SET_ALM  = 2'd2
    } mode_e;

    // Selected field index
    localparam logic [1:0] FLD_HOUR = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_SEC  = 2'd2;

    // Upper limits of a two-digit BCD field
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX   = 8'h59;

    // Increment {shi,ge}; wraps to 00 at the limit or on any non-BCD digit.
    // Valid BCD orders the same as binary, so a plain compare against the
    // limit is enough once both digits are known to be 0..9.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] value,
                                            input logic [7:0] limit);
        logic [7:0] res;
        if ((value[7:4] > 4'd9) || (value[3:0] > 4'd9) || (value >= limit)) begin
            res = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            res = {value[7:4] + 4'd1, 4'd0};
        end else begin
            res = {value[7:4], value[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Two-flop synchroniser, stability counter and falling-edge
//             detector for one active-low push-button. Emits a one-cycle
//             press pulse DB_CNT+3 cycles after the key settles low.
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DB_CNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int             CW      = (DB_CNT < 1) ? 1 : $clog2(DB_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CNT);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count how long the synchronised level has disagreed with the accepted one
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Only the high-to-low move of the accepted level is a press
        press_d = stable_q & ~stable_d;
    end

    // Synchroniser, counter, accepted level and pulse registers; keys idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_set_ctrl
//  Purpose  : Key-driven front end that edits the clock core's load digits
//             and the alarm time/enable. Editing starts from the running time.
//  Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int DB_CNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_sel_n,
    input  logic       key_inc_n,
    input  logic       key_alm_n,
    input  logic [3:0] cur_sec_ge,
    input  logic [3:0] cur_sec_shi,
    input  logic [3:0] cur_min_ge,
    input  logic [3:0] cur_min_shi,
    input  logic [3:0] cur_hour_ge,
    input  logic [3:0] cur_hour_shi,
    output logic       set_time_finish,
    output logic [3:0] set_sec_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_hour_shi,
    output logic       clock_en,
    output logic [3:0] clock_min_ge,
    output logic [3:0] clock_min_shi,
    output logic [3:0] clock_hour_ge,
    output logic [3:0] clock_hour_shi,
    output logic [1:0] mode,
    output logic [1:0] field
);
    // Key order in the pulse vector: 0 mode, 1 sel, 2 inc, 3 alm
    logic [3:0] keys_n;
    logic [3:0] press;

    assign keys_n = {key_alm_n, key_inc_n, key_sel_n, key_mode_n};

    for (genvar i = 0; i < 4; i++) begin : g_keys
        key_debounce #(
            .DB_CNT (DB_CNT)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .key_n (keys_n[i]),
            .press (press[i])
        );
    end

    mode_e      state_q, state_d;
    logic [1:0] field_q, field_d;
    logic       finish_q, finish_d;
    logic       alm_en_q, alm_en_d;
    logic [7:0] set_hour_q, set_hour_d;
    logic [7:0] set_min_q, set_min_d;
    logic [7:0] set_sec_q, set_sec_d;
    logic [7:0] alm_hour_q, alm_hour_d;
    logic [7:0] alm_min_q, alm_min_d;

    // Next state: mode beats sel beats inc; alm toggles independently
    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        finish_d   = finish_q;
        alm_en_d   = alm_en_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        set_sec_d  = set_sec_q;
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;

        if (press[0]) begin
            field_d = FLD_HOUR;
            case (state_q)
                MODE_RUN: begin
                    set_hour_d = {cur_hour_shi, cur_hour_ge};
                    set_min_d  = {cur_min_shi, cur_min_ge};
                    set_sec_d  = {cur_sec_shi, cur_sec_ge};
                    finish_d   = 1'b0;
                    state_d    = MODE_SET_TIME;
                end
                MODE_SET_TIME: begin
                    finish_d = 1'b1;
                    state_d  = MODE_SET_ALM;
                end
                default: begin
                    state_d = MODE_RUN;
                end
            endcase
        end else if (press[1]) begin
            case (state_q)
                MODE_SET_TIME: field_d = (field_q == FLD_SEC) ? FLD_HOUR : field_q + 2'd1;
                MODE_SET_ALM:  field_d = (field_q == FLD_HOUR) ? FLD_MIN : FLD_HOUR;
                default:       field_d = field_q;
            endcase
        end else if (press[2]) begin
            if (state_q == MODE_SET_TIME) begin
                case (field_q)
                    FLD_HOUR: set_hour_d = bcd2_inc(set_hour_q, HOUR_MAX);
                    FLD_MIN:  set_min_d  = bcd2_inc(set_min_q, MS_MAX);
                    FLD_SEC:  set_sec_d  = bcd2_inc(set_sec_q, MS_MAX);
                    default:  set_sec_d  = set_sec_q;
                endcase
            end else if (state_q == MODE_SET_ALM) begin
                case (field_q)
                    FLD_HOUR: alm_hour_d = bcd2_inc(alm_hour_q, HOUR_MAX);
                    FLD_MIN:  alm_min_d  = bcd2_inc(alm_min_q, MS_MAX);
                    default:  alm_min_d  = alm_min_q;
                endcase
            end
        end

        if (press[3]) begin
            alm_en_d = ~alm_en_q;
        end
    end

    // State and output registers; reset returns to RUN with the core running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MODE_RUN;
            field_q    <= FLD_HOUR;
            finish_q   <= 1'b1;
            alm_en_q   <= 1'b0;
            set_hour_q <= 8'h00;
            set_min_q  <= 8'h00;
            set_sec_q  <= 8'h00;
            alm_hour_q <= 8'h00;
            alm_min_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            field_q    <= field_d;
            finish_q   <= finish_d;
            alm_en_q   <= alm_en_d;
            set_hour_q <= set_hour_d;
            set_min_q  <= set_min_d;
            set_sec_q  <= set_sec_d;
            alm_hour_q <= alm_hour_d;
            alm_min_q  <= alm_min_d;
        end
    end

    assign mode            = state_q;
    assign field           = field_q;
    assign set_time_finish = finish_q;
    assign clock_en        = alm_en_q;
    assign {set_hour_shi, set_hour_ge}     = set_hour_q;
    assign {set_min_shi, set_min_ge}       = set_min_q;
    assign {set_sec_shi, set_sec_ge}       = set_sec_q;
    assign {clock_hour_shi, clock_hour_ge} = alm_hour_q;
    assign {clock_min_shi, clock_min_ge}   = alm_min_q;

endmodule
`default_nettype wire
